// File: rtl/pc_seq_pkg.sv
// Shared types for the PC fetch/execute sequencer: FSM states and PC-update kinds.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDPC,
        S_WAIT,
        S_LOAD,
        S_EXEC,
        S_UPD,
        S_HALT
    } seq_state_e;

    typedef enum logic [2:0] {
        UPD_NONE,
        UPD_JMP,
        UPD_BR,
        UPD_CALL,
        UPD_RET
    } upd_kind_e;

    // Priority among PC-changing decodes; halt is resolved by the caller.
    function automatic upd_kind_e decode_kind(input logic ret,
                                              input logic call,
                                              input logic jmp,
                                              input logic br);
        upd_kind_e k;
        k = UPD_NONE;
        if (ret)       k = UPD_RET;
        else if (call) k = UPD_CALL;
        else if (jmp)  k = UPD_JMP;
        else if (br)   k = UPD_BR;
        return k;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; push when full and pop when empty are dropped (caller flags the error).
module pc_ret_stack #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] top_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] top_idx;

    assign top_idx = PW'(cnt_q - CW'(1));
    assign top_o   = mem_q[top_idx];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            mem_q <= '{default: '0};
        end else if (push_i && !full_o) begin
            mem_q[PW'(cnt_q)] <= data_i;
            cnt_q             <= cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle sequencer driving the program counter's control pins:
// RDPC -> WAIT (fetch) -> LOAD (IR) -> EXEC (decode) -> UPD (PC write/count).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned AW          = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic          seq_clk,
    input  logic          seq_rst,
    input  logic          seq_run,
    input  logic          mem_ack,
    input  logic          dec_jmp,
    input  logic          dec_br,
    input  logic          dec_call,
    input  logic          dec_ret,
    input  logic          dec_halt,
    input  logic [AW-1:0] bus_target,
    input  logic [AW-1:0] ir_target,
    input  logic [AW-1:0] pc_value,
    output logic          pc_count,
    output logic          pc_dir,
    output logic          pc_wr_en,
    output logic          pc_rd_en,
    output logic [AW-1:0] pc_load_val,
    output logic          mem_req,
    output logic          ir_load,
    output logic          seq_halted,
    output logic          stk_err
);
    seq_state_e    state_q;
    upd_kind_e     kind_c;
    logic          exec_c, push_c, pop_c;
    logic          stk_full, stk_empty;
    logic [AW-1:0] stk_top, ret_addr_c;

    logic          pc_count_q, pc_wr_en_q, pc_rd_en_q;
    logic          mem_req_q, ir_load_q, seq_halted_q, stk_err_q;
    logic [AW-1:0] pc_load_val_q;

    assign kind_c     = decode_kind(dec_ret, dec_call, dec_jmp, dec_br);
    assign exec_c     = (state_q == S_EXEC) && !dec_halt;
    assign push_c     = exec_c && (kind_c == UPD_CALL);
    assign pop_c      = exec_c && (kind_c == UPD_RET);
    assign ret_addr_c = pc_value + AW'(1);

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i   (seq_clk),
        .rst_i   (seq_rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (ret_addr_c),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Outputs are set on the edge entering the state they belong to.
    always_ff @(posedge seq_clk or posedge seq_rst) begin
        if (seq_rst) begin
            state_q       <= S_IDLE;
            pc_count_q    <= 1'b0;
            pc_wr_en_q    <= 1'b0;
            pc_rd_en_q    <= 1'b0;
            pc_load_val_q <= '0;
            mem_req_q     <= 1'b0;
            ir_load_q     <= 1'b0;
            seq_halted_q  <= 1'b0;
            stk_err_q     <= 1'b0;
        end else begin
            pc_count_q <= 1'b0;
            pc_wr_en_q <= 1'b0;
            pc_rd_en_q <= 1'b0;
            ir_load_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seq_run) begin
                        state_q    <= S_RDPC;
                        pc_rd_en_q <= 1'b1;
                    end
                end
                S_RDPC: begin
                    state_q   <= S_WAIT;
                    mem_req_q <= 1'b1;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state_q   <= S_LOAD;
                        mem_req_q <= 1'b0;
                        ir_load_q <= 1'b1;
                    end
                end
                S_LOAD: state_q <= S_EXEC;
                S_EXEC: begin
                    if (dec_halt) begin
                        state_q      <= S_HALT;
                        seq_halted_q <= 1'b1;
                    end else begin
                        state_q <= S_UPD;
                        case (kind_c)
                            UPD_RET: begin
                                if (stk_empty) begin
                                    pc_count_q <= 1'b1;
                                    stk_err_q  <= 1'b1;
                                end else begin
                                    pc_wr_en_q    <= 1'b1;
                                    pc_load_val_q <= stk_top;
                                end
                            end
                            UPD_CALL: begin
                                if (stk_full) stk_err_q <= 1'b1;
                                pc_wr_en_q    <= 1'b1;
                                pc_load_val_q <= ir_target;
                            end
                            UPD_JMP: begin
                                pc_wr_en_q    <= 1'b1;
                                pc_load_val_q <= bus_target;
                            end
                            UPD_BR: begin
                                pc_wr_en_q    <= 1'b1;
                                pc_load_val_q <= ir_target;
                            end
                            default: pc_count_q <= 1'b1;
                        endcase
                    end
                end
                S_UPD: begin
                    if (seq_run) begin
                        state_q    <= S_RDPC;
                        pc_rd_en_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_count    = pc_count_q;
    assign pc_dir      = 1'b0;
    assign pc_wr_en    = pc_wr_en_q;
    assign pc_rd_en    = pc_rd_en_q;
    assign pc_load_val = pc_load_val_q;
    assign mem_req     = mem_req_q;
    assign ir_load     = ir_load_q;
    assign seq_halted  = seq_halted_q;
    assign stk_err     = stk_err_q;

endmodule
